// File: rtl/uart_blk_sequencer_pkg.sv
// Shared types and constants for the UART block sequencer.
// State encoding, battery level codes and default divider ratios.
package uart_blk_sequencer_pkg;

   typedef enum logic [1:0] {
      S_KEY  = 2'd0,
      S_FILL = 2'd1,
      S_CIPH = 2'd2,
      S_TX   = 2'd3
   } state_e;

   localparam logic [1:0] LVL_FULL  = 2'd1;
   localparam logic [1:0] LVL_MID   = 2'd2;
   localparam logic [1:0] LVL_RESET = 2'd3;

   localparam int DIV_L1_DEF = 1;
   localparam int DIV_L2_DEF = 4;
   localparam int DIV_L3_DEF = 8;

   function automatic int max2(
      input int a,
      input int b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_blk_sequencer_if.sv
// Bundle between the UART/cipher glue and its surroundings.
// master drives RX bytes and cipher/TX status; slave is the sequencer.
interface uart_blk_sequencer_if #(
   parameter int KEY_W = 128,
   parameter int RND_W = 384,
   parameter int GRP_W = 32
);

   logic [7:0]       rx_byte;
   logic             rx_valid;
   logic             flush;
   logic [1:0]       battery_level;
   logic             cipher_done;
   logic             tx_done;

   logic [KEY_W-1:0] key;
   logic [RND_W-1:0] round_data;
   logic             cipher_start;
   logic             cipher_ce;
   logic             tx_start;
   logic [GRP_W-1:0] group_num;
   logic             busy;
   logic             overrun;

   modport master (
      output rx_byte,
      output rx_valid,
      output flush,
      output battery_level,
      output cipher_done,
      output tx_done,
      input  key,
      input  round_data,
      input  cipher_start,
      input  cipher_ce,
      input  tx_start,
      input  group_num,
      input  busy,
      input  overrun
   );

   modport slave (
      input  rx_byte,
      input  rx_valid,
      input  flush,
      input  battery_level,
      input  cipher_done,
      input  tx_done,
      output key,
      output round_data,
      output cipher_start,
      output cipher_ce,
      output tx_start,
      output group_num,
      output busy,
      output overrun
   );

endinterface

// File: rtl/uart_blk_sequencer_ce_divider.sv
// Cipher clock-enable generator: ratio picked from the battery level
// latched at launch, counter restarted so the launch cycle is enabled.
module uart_blk_sequencer_ce_divider
   import uart_blk_sequencer_pkg::*;
#(
   parameter int DIV_L1 = DIV_L1_DEF,
   parameter int DIV_L2 = DIV_L2_DEF,
   parameter int DIV_L3 = DIV_L3_DEF
) (
   input  logic       clk,
   input  logic       Rst_n,
   input  logic       restart_i,
   input  logic [1:0] lvl_i,
   input  logic       en_i,
   output logic       ce_o
);

   localparam int DMAX = max2(max2(DIV_L1, DIV_L2), DIV_L3);
   localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;

   localparam logic [CW-1:0] LAST_L1 = CW'(DIV_L1 - 1);
   localparam logic [CW-1:0] LAST_L2 = CW'(DIV_L2 - 1);
   localparam logic [CW-1:0] LAST_L3 = CW'(DIV_L3 - 1);

   logic [1:0]    lvl_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] last;

   always_comb begin
      last = LAST_L3;
      unique case (1'b1)
         (lvl_q == LVL_FULL): last = LAST_L1;
         (lvl_q == LVL_MID):  last = LAST_L2;
         default:             last = LAST_L3;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == last) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         lvl_q <= LVL_RESET;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (restart_i) begin
            lvl_q <= lvl_i;
         end
      end
   end

   assign ce_o = en_i & (cnt_q == '0);

endmodule

// File: rtl/uart_blk_sequencer.sv
// UART/cipher glue: builds key and rounds from RX bytes, launches the
// cipher, hands off to TX and counts completed groups.
module uart_blk_sequencer
   import uart_blk_sequencer_pkg::*;
#(
   parameter int BLK_W         = 128,
   parameter int BLK_PER_ROUND = 3,
   parameter int KEY_W         = 128,
   parameter int GRP_W         = 32,
   parameter int DIV_L1        = DIV_L1_DEF,
   parameter int DIV_L2        = DIV_L2_DEF,
   parameter int DIV_L3        = DIV_L3_DEF
) (
   input logic                clk,
   input logic                Rst_n,
   uart_blk_sequencer_if.slave bus
);

   localparam int RND_W = BLK_W * BLK_PER_ROUND;
   localparam int KB    = KEY_W / 8;
   localparam int RB    = RND_W / 8;
   localparam int CW    = $clog2(max2(KB, RB) + 1);

   localparam logic [CW-1:0] KB_LAST = CW'(KB - 1);
   localparam logic [CW-1:0] RB_FULL = CW'(RB);

   state_e           state_q;
   logic [KEY_W-1:0] key_q;
   logic [RND_W-1:0] rnd_q;
   logic [CW-1:0]    cnt_q;
   logic             start_q;
   logic             tx_q;
   logic [GRP_W-1:0] grp_q;
   logic             ovr_q;

   logic [RND_W-1:0] fill_dat_d;
   logic [CW-1:0]    fill_cnt_d;
   logic [CW-1:0]    pad_cnt_d;
   logic [RND_W-1:0] pad_dat_d;
   logic             launch_d;
   logic             ce;

   // Byte accepted first, then flush left-justifies what is there.
   always_comb begin
      fill_dat_d = rnd_q;
      fill_cnt_d = cnt_q;
      if (bus.rx_valid) begin
         fill_dat_d = {rnd_q[RND_W-9:0], bus.rx_byte};
         fill_cnt_d = cnt_q + 1'b1;
      end
      launch_d  = (fill_cnt_d == RB_FULL) ||
                  (bus.flush && (fill_cnt_d != '0));
      pad_cnt_d = RB_FULL - fill_cnt_d;
      pad_dat_d = fill_dat_d << {pad_cnt_d, 3'b000};
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_KEY;
         key_q   <= '0;
         rnd_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         tx_q    <= 1'b0;
         grp_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         tx_q    <= 1'b0;
         unique case (state_q)
            S_KEY: begin
               if (bus.rx_valid) begin
                  key_q <= {key_q[KEY_W-9:0], bus.rx_byte};
                  if (cnt_q == KB_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_FILL;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (launch_d) begin
                  rnd_q   <= pad_dat_d;
                  cnt_q   <= '0;
                  start_q <= 1'b1;
                  state_q <= S_CIPH;
               end else begin
                  rnd_q <= fill_dat_d;
                  cnt_q <= fill_cnt_d;
               end
            end
            S_CIPH: begin
               if (bus.rx_valid) begin
                  ovr_q <= 1'b1;
               end
               // A done level still high from the last round is stale.
               if (bus.cipher_done && !start_q) begin
                  tx_q    <= 1'b1;
                  state_q <= S_TX;
               end
            end
            S_TX: begin
               if (bus.rx_valid) begin
                  ovr_q <= 1'b1;
               end
               if (bus.tx_done) begin
                  grp_q   <= grp_q + 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_FILL;
               end
            end
            default: begin
               state_q <= S_KEY;
            end
         endcase
      end
   end

   uart_blk_sequencer_ce_divider #(
      .DIV_L1 (DIV_L1),
      .DIV_L2 (DIV_L2),
      .DIV_L3 (DIV_L3)
   ) u_ce_div (
      .clk       (clk),
      .Rst_n     (Rst_n),
      .restart_i ((state_q == S_FILL) && launch_d),
      .lvl_i     (bus.battery_level),
      .en_i      (state_q == S_CIPH),
      .ce_o      (ce)
   );

   assign bus.key          = key_q;
   assign bus.round_data   = rnd_q;
   assign bus.cipher_start = start_q;
   assign bus.cipher_ce    = ce;
   assign bus.tx_start     = tx_q;
   assign bus.group_num    = grp_q;
   assign bus.busy         = (state_q == S_CIPH) || (state_q == S_TX);
   assign bus.overrun      = ovr_q;

endmodule
